// File: rtl/conv_pe_pkg.sv
// Shared types and elaboration helpers for the conv_pe processing element.
package conv_pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned taps(input int unsigned k0, input int unsigned k1,
                                       input int unsigned ic);
    return k0 * k1 * ic;
  endfunction

  function automatic int unsigned min_acc_width(input int unsigned dw, input int unsigned t);
    return 2 * dw + clog2(t) + 1;
  endfunction

  localparam int unsigned DEF_TAPS          = taps(3, 3, 1);
  localparam int unsigned DEF_MIN_ACC_WIDTH = min_acc_width(8, DEF_TAPS);

endpackage

// File: rtl/conv_pe_dot.sv
// Combinational signed dot product of one window against one filter row, plus bias.
module conv_pe_dot
  import conv_pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAPS       = DEF_TAPS,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic        [DATA_WIDTH*TAPS-1:0] i_window,
  input  logic        [DATA_WIDTH*TAPS-1:0] i_weights,
  input  logic signed [ACC_WIDTH-1:0]       i_bias,
  output logic signed [ACC_WIDTH-1:0]       o_sum
);

  logic signed [2*DATA_WIDTH-1:0] w_prod [TAPS];

  always_comb begin
    for (int unsigned t = 0; t < TAPS; t++) begin
      w_prod[t] = $signed(i_window[t*DATA_WIDTH +: DATA_WIDTH])
                * $signed(i_weights[t*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Size cast of a signed product sign-extends it to the accumulator width.
  always_comb begin
    o_sum = i_bias;
    for (int unsigned t = 0; t < TAPS; t++) begin
      o_sum = o_sum + ACC_WIDTH'(w_prod[t]);
    end
  end

endmodule

// File: rtl/conv_pe.sv
// Convolution PE: one window per handshake, OUT_CHANNEL filtered results streamed out.
// Optional CONV_PE_RELU_EN clamps negative results to zero.
module conv_pe
  import conv_pe_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned IN_CHANNEL  = 1,
  parameter  int unsigned KERNEL_0    = 3,
  parameter  int unsigned KERNEL_1    = 3,
  parameter  int unsigned OUT_CHANNEL = 4,
  parameter  int unsigned ACC_WIDTH   = 20,
  localparam int unsigned TAPS        = taps(KERNEL_0, KERNEL_1, IN_CHANNEL),
  localparam int unsigned CH_W        = (OUT_CHANNEL > 1) ? clog2(OUT_CHANNEL) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [DATA_WIDTH*TAPS-1:0] i_data,
  input  logic                         i_valid,
  output logic                         pe_ready,
  output logic                         pe_ack,
  input  logic                         wgt_wr_en,
  input  logic        [CH_W-1:0]       wgt_addr,
  input  logic        [DATA_WIDTH*TAPS-1:0] wgt_data,
  input  logic signed [ACC_WIDTH-1:0]  bias_data,
  output logic signed [ACC_WIDTH-1:0]  o_data,
  output logic        [CH_W-1:0]       o_channel,
  output logic                         o_valid,
  input  logic                         o_ready
);

  state_t r_state, w_next;

  logic        [DATA_WIDTH*TAPS-1:0] r_window;
  logic        [DATA_WIDTH*TAPS-1:0] r_wgt  [OUT_CHANNEL];
  logic signed [ACC_WIDTH-1:0]       r_bias [OUT_CHANNEL];
  logic        [CH_W-1:0]            r_ch;
  logic                              r_ack;
  logic                              r_ready;
  logic signed [ACC_WIDTH-1:0]       r_result;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_res;
  logic                        w_accept;
  logic                        w_hs;
  logic                        w_last;
  logic                        w_wr;

  // r_ready mirrors "next state is IDLE", so it is low for the cycle after reset.
  assign w_accept = r_ready && i_valid;
  assign w_hs     = (r_state == OUT) && o_ready;
  assign w_last   = (r_ch == CH_W'(OUT_CHANNEL - 1));
  assign w_wr     = wgt_wr_en && (r_state == IDLE)
                 && ({1'b0, wgt_addr} < (CH_W + 1)'(OUT_CHANNEL));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    w_next = OUT;
      OUT:     if (w_hs) w_next = w_last ? IDLE : CALC;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    pe_ready  = r_ready;
    pe_ack    = r_ack;
    o_valid   = (r_state == OUT);
    o_data    = r_result;
    o_channel = r_ch;
  end

  conv_pe_dot #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAPS       (TAPS),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dot (
    .i_window  (r_window),
    .i_weights (r_wgt[r_ch]),
    .i_bias    (r_bias[r_ch]),
    .o_sum     (w_sum)
  );

  always_comb begin
`ifdef CONV_PE_RELU_EN
    w_res = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
    w_res = w_sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b0;
      r_ack    <= 1'b0;
      r_ch     <= '0;
      r_window <= '0;
      r_result <= '0;
      for (int unsigned i = 0; i < OUT_CHANNEL; i++) begin
        r_wgt[i]  <= '0;
        r_bias[i] <= '0;
      end
    end else begin
      r_ready <= (w_next == IDLE);
      r_ack   <= w_accept;
      if (w_accept) begin
        r_window <= i_data;
        r_ch     <= '0;
      end
      if (r_state == CALC) r_result <= w_res;
      if (w_hs) r_ch <= w_last ? '0 : r_ch + CH_W'(1);
      if (w_wr) begin
        r_wgt[wgt_addr]  <= wgt_data;
        r_bias[wgt_addr] <= bias_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_pe.sv
// Scoreboard bench for conv_pe: expected results queued at window issue, checked on output.
module tb_conv_pe;

  localparam int DW   = 8;
  localparam int TAPS = 9;
  localparam int ACC  = 20;
  localparam int OC   = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [DW*TAPS-1:0]       i_data;
  logic                     i_valid;
  logic                     pe_ready;
  logic                     pe_ack;
  logic                     wgt_wr_en;
  logic [1:0]               wgt_addr;
  logic [DW*TAPS-1:0]       wgt_data;
  logic signed [ACC-1:0]    bias_data;
  logic signed [ACC-1:0]    o_data;
  logic [1:0]               o_channel;
  logic                     o_valid;
  logic                     o_ready;

  conv_pe #(
    .DATA_WIDTH  (DW),
    .IN_CHANNEL  (1),
    .KERNEL_0    (3),
    .KERNEL_1    (3),
    .OUT_CHANNEL (OC),
    .ACC_WIDTH   (ACC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .pe_ready  (pe_ready),
    .pe_ack    (pe_ack),
    .wgt_wr_en (wgt_wr_en),
    .wgt_addr  (wgt_addr),
    .wgt_data  (wgt_data),
    .bias_data (bias_data),
    .o_data    (o_data),
    .o_channel (o_channel),
    .o_valid   (o_valid),
    .o_ready   (o_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pe_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];

  logic [DW*TAPS-1:0] m_w [OC];
  int                 m_b [OC];

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DW*TAPS-1:0] fill(input int v);
    logic [DW*TAPS-1:0] r;
    for (int t = 0; t < TAPS; t++) r[t*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [DW*TAPS-1:0] rand_win();
    logic [DW*TAPS-1:0] r;
    for (int t = 0; t < TAPS; t++) r[t*DW +: DW] = DW'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic int model(input logic [DW*TAPS-1:0] win, input int ch);
    int s;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    s = m_b[ch];
    for (int t = 0; t < TAPS; t++) begin
      a = win[t*DW +: DW];
      b = m_w[ch][t*DW +: DW];
      s += int'(a) * int'(b);
    end
`ifdef CONV_PE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic push_model(input logic [DW*TAPS-1:0] win);
    for (int c = 0; c < OC; c++) exp_q.push_back('{c, model(win, c)});
  endtask

  task automatic write_filter(input int ch, input logic [DW*TAPS-1:0] w, input int b);
    wgt_wr_en = 1'b1;
    wgt_addr  = 2'(ch);
    wgt_data  = w;
    bias_data = ACC'(b);
    tick();
    wgt_wr_en = 1'b0;
    m_w[ch] = w;
    m_b[ch] = b;
  endtask

  // Pops one expected entry per result; t_acc is cyc sampled in the ack cycle.
  task automatic drain(input int stall_ch, input int stall_len, input int t_acc, input bit chk_t);
    exp_t e;
    int waited;
    for (int n = 0; n < OC; n++) begin
      waited = 0;
      while (o_valid !== 1'b1 && waited < 12) begin
        tick();
        waited++;
      end
      checks++;
      if (o_valid !== 1'b1) begin
        errors++;
        $display("FAIL result_timeout n=%0d got o_valid=%b expected 1", n, o_valid);
        return;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow got ch=%0d data=%0d expected nothing", o_channel, o_data);
        return;
      end
      e = exp_q.pop_front();
      if (o_channel !== 2'(e.ch) || o_data !== ACC'(e.data)) begin
        errors++;
        $display("FAIL result got ch=%0d data=%0d expected ch=%0d data=%0d",
                 o_channel, o_data, e.ch, e.data);
      end
      if (chk_t) begin
        checks++;
        if (cyc !== t_acc + 1 + 2 * n) begin
          errors++;
          $display("FAIL result_time ch=%0d got cycle %0d expected %0d", n, cyc - t_acc, 1 + 2 * n);
        end
      end
      if (n == stall_ch) begin
        o_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          checks++;
          if (o_valid !== 1'b1 || o_channel !== 2'(e.ch) || o_data !== ACC'(e.data)) begin
            errors++;
            $display("FAIL stall_hold k=%0d got v=%b ch=%0d data=%0d expected v=1 ch=%0d data=%0d",
                     k, o_valid, o_channel, o_data, e.ch, e.data);
          end
        end
        o_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (pe_ready !== 1'b0 || pe_ack !== 1'b0 || o_valid !== 1'b0 || o_data !== '0 || o_channel !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b ack=%b v=%b data=%0d ch=%0d expected all 0",
               pe_ready, pe_ack, o_valid, o_data, o_channel);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pe_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 1", pe_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW*TAPS-1:0] win, ramp;
    int t_acc;
    for (int t = 0; t < TAPS; t++) begin
      win[t*DW +: DW]  = DW'(t + 1);
      ramp[t*DW +: DW] = DW'(t - 4);
    end
    write_filter(0, fill(1), 0);
    write_filter(1, fill(-1), 5);
    write_filter(2, ramp, -100);
    write_filter(3, fill(2), 1000);
    exp_q.push_back('{0, 45});
`ifdef CONV_PE_RELU_EN
    exp_q.push_back('{1, 0});
`else
    exp_q.push_back('{1, -40});
`endif
    exp_q.push_back('{2, model(win, 2)});
    exp_q.push_back('{3, model(win, 3)});
    i_data  = win;
    i_valid = 1'b1;
    tick();
    t_acc = cyc;
    checks++;
    if (pe_ack !== 1'b1 || pe_ready !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_cycle got ack=%b rdy=%b v=%b expected ack=1 rdy=0 v=0", pe_ack, pe_ready, o_valid);
    end
    i_valid = 1'b0;
    tick();
    checks++;
    if (pe_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_width got %b expected 0", pe_ack);
    end
    drain(-1, 0, t_acc, 1'b1);
    checks++;
    if (pe_ready !== 1'b1 || cyc !== t_acc + 8) begin
      errors++;
      $display("FAIL ready_return got rdy=%b at +%0d expected rdy=1 at +8", pe_ready, cyc - t_acc);
    end
  endtask

  task automatic test_no_overflow();
    int t_acc;
    write_filter(0, fill(-128), 0);
    exp_q.push_back('{0, 147456});
    for (int c = 1; c < OC; c++) exp_q.push_back('{c, model(fill(-128), c)});
    i_data  = fill(-128);
    i_valid = 1'b1;
    tick();
    t_acc   = cyc;
    i_valid = 1'b0;
    drain(-1, 0, t_acc, 1'b1);
  endtask

  task automatic test_stall();
    logic [DW*TAPS-1:0] win;
    int t_acc;
    win = rand_win();
    push_model(win);
    i_data  = win;
    i_valid = 1'b1;
    tick();
    t_acc   = cyc;
    i_valid = 1'b0;
    drain(1, 5, t_acc, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [DW*TAPS-1:0] win_a, win_b;
    int t_acc, t2, a0;
    win_a = rand_win();
    win_b = rand_win();
    push_model(win_a);
    i_data  = win_a;
    i_valid = 1'b1;
    tick();
    t_acc = cyc;
    checks++;
    if (pe_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ack got %b expected 1", pe_ack);
    end
    i_data    = win_b;
    wgt_wr_en = 1'b1;
    wgt_addr  = 2'd2;
    wgt_data  = fill(7);
    bias_data = ACC'(333);
    tick();
    wgt_wr_en = 1'b0;
    a0 = ack_cnt;
    drain(-1, 0, t_acc, 1'b1);
    checks++;
    if (pe_ready !== 1'b1 || pe_ack !== 1'b0 || ack_cnt !== a0 || cyc !== t_acc + 8) begin
      errors++;
      $display("FAIL b2b_hold got rdy=%b ack=%b extra_acks=%0d at +%0d expected rdy=1 ack=0 extra=0 at +8",
               pe_ready, pe_ack, ack_cnt - a0, cyc - t_acc);
    end
    push_model(win_b);
    tick();
    checks++;
    if (pe_ack !== 1'b1 || cyc !== t_acc + 9) begin
      errors++;
      $display("FAIL b2b_second_ack got ack=%b at +%0d expected ack=1 at +9", pe_ack, cyc - t_acc);
    end
    t2 = cyc;
    i_valid = 1'b0;
    drain(-1, 0, t2, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [DW*TAPS-1:0] win;
    int waited, t_acc;
    i_data  = rand_win();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    waited  = 0;
    while (!(o_valid === 1'b1 && o_channel === 2'd2) && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!(o_valid === 1'b1 && o_channel === 2'd2)) begin
      errors++;
      $display("FAIL reach_ch2 got v=%b ch=%0d expected v=1 ch=2", o_valid, o_channel);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_channel !== '0 || pe_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b data=%0d ch=%0d rdy=%b expected all 0",
               o_valid, o_data, o_channel, pe_ready);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pe_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready got %b expected 1", pe_ready);
    end
    for (int c = 0; c < OC; c++) begin
      m_w[c] = '0;
      m_b[c] = 0;
    end
    exp_q.delete();
    win = rand_win();
    push_model(win);
    i_data  = win;
    i_valid = 1'b1;
    tick();
    t_acc   = cyc;
    i_valid = 1'b0;
    drain(-1, 0, t_acc, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    i_data    = '0;
    i_valid   = 1'b0;
    wgt_wr_en = 1'b0;
    wgt_addr  = '0;
    wgt_data  = '0;
    bias_data = '0;
    o_ready   = 1'b1;
    for (int c = 0; c < OC; c++) begin
      m_w[c] = '0;
      m_b[c] = 0;
    end
    test_reset();
    test_basic();
    test_no_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

endmodule
